sram_photo_reader: RTL

Playback stage downstream of the frame saver. Reads a stored 320x240 photo from SRAM and serves it, upscaled 2x2, to the VGA controller's pixel request stream. Photo rows are prefetched into a ping-pong line buffer so SRAM reads never race VGA timing. Sits between the SRAM arbiter's read port and the iRed/iGreen/iBlue inputs of VGA_Controller.

---
 rtl/sram_photo_reader.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/sram_photo_reader.sv
// sram_photo_reader
// Plays back a stored 320x240 photo from SRAM, upscaled 2x2, into the VGA
// pixel request stream. Photo rows are prefetched into a ping-pong line
// buffer: buf0 holds even rows, buf1 holds odd rows.
//
// Ports
//   iCLK, iRST_N        pixel clock, async active-low reset
//   iEnable             playback enable, latched at frame start
//   iPhoto_Index        photo slot (clamped to MAX_INDEX), latched at frame start
//   iVGA_Read           VGA pixel request, high during active pixels
//   iVGA_VSYNC          vertical sync, active low; falling edge = frame start
//   iSRAM_DQ            SRAM read data
//   oSRAM_Addr          SRAM word address
//   oSRAM_*_N           active-low SRAM strobes (WE_N tied high)
//   oRGB                {R,G,B} 10 bits each, registered
//   oBusy               line fill in progress
//   oUnderrun           sticky: a buffer was displayed while still filling
//
// Fill FSM
//   state | meaning
//   IDLE  | no fill running
//   ADDR  | first word address of a row driven
//   READ  | 640 cycles, one word sampled per cycle
module sram_photo_reader #(
  parameter int COL_MAX   = 320,
  parameter int ROW_MAX   = 240,
  parameter int MAX_INDEX = 5
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iEnable,
  input  logic [2:0]  iPhoto_Index,
  input  logic        iVGA_Read,
  input  logic        iVGA_VSYNC,
  input  logic [15:0] iSRAM_DQ,
  output logic [19:0] oSRAM_Addr,
  output logic        oSRAM_CE_N,
  output logic        oSRAM_OE_N,
  output logic        oSRAM_UB_N,
  output logic        oSRAM_LB_N,
  output logic        oSRAM_WE_N,
  output logic [29:0] oRGB,
  output logic        oBusy,
  output logic        oUnderrun
);

  localparam int WORDS       = 2 * COL_MAX;
  localparam int LINES       = 2 * ROW_MAX;
  localparam int FRAME_WORDS = 2 * COL_MAX * ROW_MAX;

  typedef enum logic [1:0] {IDLE, ADDR, READ} state_t;

  state_t      state_q, state_d;
  logic        vsync_d, read_d;
  logic        frame_start, read_fall;
  logic        en_q;
  logic [2:0]  idx_c;
  logic [19:0] base_new, base_q;
  logic [7:0]  fill_row, pend_row;
  logic [19:0] fill_base;
  logic [9:0]  cnt;
  logic [9:0]  addr_off;
  logic        pend;
  logic        load_pend;
  logic [15:0] half_q;
  logic [9:0]  line_q, col_q;
  logic [29:0] rgb_q;
  logic        underrun_q;
  logic        busy;
  logic        swap;
  logic [7:0]  disp_row, next_row;
  logic [8:0]  refill_row;
  logic        wr_en;
  logic [29:0] wr_pix;
  logic        show;
  logic        unused_dq;

  logic [29:0] buf0 [COL_MAX];
  logic [29:0] buf1 [COL_MAX];

  function automatic logic [19:0] row_offset(input logic [7:0] row);
    return (20'(row) << 9) + (20'(row) << 7);
  endfunction

  assign frame_start = vsync_d & ~iVGA_VSYNC;
  assign read_fall   = read_d & ~iVGA_Read;
  assign busy        = (state_q != IDLE);

  always_comb begin
    idx_c = iPhoto_Index;
    if (iPhoto_Index > 3'(MAX_INDEX)) idx_c = 3'(MAX_INDEX);
  end
  assign base_new = 20'(idx_c) * 20'(FRAME_WORDS);

  // Swap happens at the end of the second VGA line of a photo row.
  assign disp_row   = line_q[8:1];
  assign next_row   = disp_row + 8'd1;
  assign refill_row = {1'b0, disp_row} + 9'd2;
  assign swap       = read_fall && en_q && (line_q < 10'(LINES)) && line_q[0] && !frame_start;

  always_comb begin
    state_d = state_q;
    if (frame_start) begin
      state_d = iEnable ? ADDR : IDLE;
    end else begin
      case (state_q)
        IDLE:    if (pend && en_q) state_d = ADDR;
        ADDR:    state_d = READ;
        READ:    if (cnt == 10'(WORDS - 1)) state_d = pend ? ADDR : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Entering ADDR outside a frame start always comes from the pending slot.
  assign load_pend = !frame_start && (state_d == ADDR);

  // Address leads the sampled word by one; the last READ cycle holds it.
  always_comb begin
    addr_off = '0;
    if (state_q == READ) addr_off = (cnt >= 10'(WORDS - 1)) ? 10'(WORDS - 1) : cnt + 10'd1;
  end
  assign oSRAM_Addr = fill_base + 20'(addr_off);

  assign wr_en  = (state_q == READ) && cnt[0];
  assign wr_pix = {half_q, iSRAM_DQ[15:2]};
  assign show   = iVGA_Read && en_q && (line_q < 10'(LINES));
  assign unused_dq = ^iSRAM_DQ[1:0];

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q    <= IDLE;
      vsync_d    <= 1'b1;
      read_d     <= 1'b0;
      en_q       <= 1'b0;
      base_q     <= '0;
      fill_row   <= '0;
      fill_base  <= '0;
      cnt        <= '0;
      pend       <= 1'b0;
      pend_row   <= '0;
      half_q     <= '0;
      line_q     <= '0;
      col_q      <= '0;
      rgb_q      <= '0;
      underrun_q <= 1'b0;
    end else begin
      vsync_d <= iVGA_VSYNC;
      read_d  <= iVGA_Read;
      state_q <= state_d;

      if (state_q == READ) cnt <= cnt + 10'd1;
      else                 cnt <= '0;
      if (state_q == READ && !cnt[0]) half_q <= iSRAM_DQ;

      if (frame_start) begin
        en_q       <= iEnable;
        base_q     <= base_new;
        line_q     <= '0;
        col_q      <= '0;
        underrun_q <= 1'b0;
        fill_row   <= '0;
        cnt        <= '0;
        pend       <= iEnable;
        pend_row   <= 8'd1;
        if (iEnable) fill_base <= base_new;
      end else begin
        if (load_pend) begin
          fill_row  <= pend_row;
          fill_base <= base_q + row_offset(pend_row);
          pend      <= 1'b0;
        end
        // A swap in the same cycle as a load re-arms the slot with the new row.
        if (swap) begin
          if (refill_row <= 9'(ROW_MAX - 1)) begin
            pend     <= 1'b1;
            pend_row <= refill_row[7:0];
          end
          if ((busy && fill_row == next_row) || (pend && pend_row == next_row))
            underrun_q <= 1'b1;
        end
        if (read_fall) begin
          col_q <= '0;
          if (line_q < 10'(LINES)) line_q <= line_q + 10'd1;
        end else if (iVGA_Read && col_q < 10'(WORDS - 1)) begin
          col_q <= col_q + 10'd1;
        end
      end

      if (show) rgb_q <= line_q[1] ? buf1[col_q[9:1]] : buf0[col_q[9:1]];
      else      rgb_q <= '0;
    end
  end

  always_ff @(posedge iCLK) begin
    if (wr_en) begin
      if (fill_row[0]) buf1[cnt[9:1]] <= wr_pix;
      else             buf0[cnt[9:1]] <= wr_pix;
    end
  end

  assign oSRAM_CE_N = ~busy;
  assign oSRAM_OE_N = ~busy;
  assign oSRAM_UB_N = ~busy;
  assign oSRAM_LB_N = ~busy;
  assign oSRAM_WE_N = 1'b1;
  assign oRGB       = rgb_q;
  assign oBusy      = busy;
  assign oUnderrun  = underrun_q;

endmodule
